// File: rtl/ysyx_040729_exe_alu_multiplier.sv
// Iterative radix-2 shift-add multiplier for the EXE ALU (MUL/MULH/MULHSU/MULHU).
// It multiplies operand magnitudes over WIDTH cycles, then applies the sign in a single fix-up cycle.
//   state  | meaning
//   S_IDLE | ready for an operand pair; results hold the last product
//   S_BUSY | one shift-add iteration per cycle, WIDTH cycles in total
//   S_FIX  | apply the sign to the unsigned product
//   S_DONE | product valid, waiting for out_ready
module ysyx_040729_exe_alu_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_valid,
  output logic             mul_ready,
  input  logic [1:0]       mul_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_last;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  // Mode 2'b01 has no RISC-V meaning and falls through to unsigned*unsigned.
  assign w_sign_a = mul_signed[1] & multiplicand[WIDTH-1];
  assign w_sign_b = (mul_signed == 2'b11) & multiplier[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign w_mag_b  = w_sign_b ? (~multiplier + WIDTH'(1)) : multiplier;

  assign w_accept = (r_state == S_IDLE) && mul_valid && !flush;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum    = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod   = {r_acc, r_mplier};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mul_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_FIX;
      S_FIX:                  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_mcand  <= w_mag_a;
      r_acc    <= '0;
      r_mplier <= w_mag_b;
      r_neg    <= w_sign_a ^ w_sign_b;
    end else if (!flush) begin
      if (r_state == S_BUSY) begin
        // The carry out of the add lands in the accumulator MSB after the shift.
        r_acc    <= w_sum[WIDTH:1];
        r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_FIX) begin
        r_prod <= r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
      end
    end
  end

  assign mul_ready = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result_hi = r_prod[2*WIDTH-1:WIDTH];
  assign result_lo = r_prod[WIDTH-1:0];

endmodule

// File: tb/tb_ysyx_040729_exe_alu_multiplier.sv
// Directed and lightly randomised bench for the EXE ALU multiplier (WIDTH=32).
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_ysyx_040729_exe_alu_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_valid;
  logic        mul_ready;
  logic [1:0]  mul_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_040729_exe_alu_multiplier #(.WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept edge ends cycle c; out_valid first rises in cycle c+34, i.e. 33 edges later.
  task automatic accept(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    mul_signed   = m;
    multiplicand = a;
    multiplier   = b;
    mul_valid    = 1'b1;
    step();
    mul_valid    = 1'b0;
    // Operands are sampled only at the accept edge, so scrambling them here must be harmless.
    mul_signed   = ~m;
    multiplicand = ~a;
    multiplier   = a ^ b ^ 32'h5A5A_A5A5;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      step();
      edges++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int edges;
    chk({tag, ".ready"}, 64'(mul_ready), 64'd1);
    accept(m, a, b);
    wait_valid(edges);
    chk({tag, ".latency"}, 64'(edges), 64'd33);
    chk({tag, ".product"}, {result_hi, result_lo}, exp);
    consume();
    chk({tag, ".idle"}, {62'd0, out_valid, mul_ready}, 64'b01);
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = m[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (m == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  initial begin
    int edges;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rm;
    logic [63:0] held;

    rst = 1'b1; mul_valid = 1'b0; mul_signed = 2'b00;
    multiplicand = '0; multiplier = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk("reset.outs", {result_hi, result_lo}, 64'd0);
    chk("reset.ctrl", {62'd0, out_valid, mul_ready}, 64'b01);

    run_op("uu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("ss_minm1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("ss_m3x7",  2'b11, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
    run_op("su_m1",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_op("mode01",   2'b01, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB);
    run_op("zero",     2'b11, 32'd0,         32'h8000_0000, 64'd0);

    // Backpressure: DONE holds results and refuses operands until out_ready.
    accept(2'b00, 32'd1000, 32'd3);
    wait_valid(edges);
    chk("bp.latency", 64'(edges), 64'd33);
    held = {result_hi, result_lo};
    chk("bp.product", held, 64'd3000);
    mul_valid = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mul_ready || !out_valid || {result_hi, result_lo} != held) seen++;
    end
    mul_valid = 1'b0;
    chk("bp.stable", 64'(seen), 64'd0);
    consume();
    chk("bp.release", {62'd0, out_valid, mul_ready}, 64'b01);
    run_op("bp.next", 2'b00, 32'd12, 32'd12, 64'd144);

    // Flush during BUSY iteration 15.
    accept(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < 15; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.busy", {62'd0, out_valid, mul_ready}, 64'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("flush.novalid", 64'(seen), 64'd0);
    chk("flush.keepres", {result_hi, result_lo}, 64'd144);

    // Flush together with mul_valid in IDLE must not accept.
    mul_valid = 1'b1; flush = 1'b1; multiplicand = 32'd5; multiplier = 32'd5;
    step();
    mul_valid = 1'b0; flush = 1'b0;
    chk("flush.idle", {62'd0, out_valid, mul_ready}, 64'b01);
    run_op("flush.follow", 2'b00, 32'd6, 32'd7, 64'd42);

    // Flush in DONE with out_ready counts as consumed.
    accept(2'b11, 32'hFFFF_FFFE, 32'd5);
    wait_valid(edges);
    chk("fdone.product", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF6);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("fdone.idle", {62'd0, out_valid, mul_ready}, 64'b01);

    // Reset in the middle of BUSY clears everything.
    accept(2'b00, 32'd77, 32'd77);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("rst.mid.outs", {result_hi, result_lo}, 64'd0);
    chk("rst.mid.ctrl", {62'd0, out_valid, mul_ready}, 64'b01);

    // Short random run per mode against a 64-bit reference multiply.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 12; i++) begin
        rm = 2'(m);
        ra = $urandom();
        rb = $urandom();
        if (i == 0) ra = 32'h8000_0000;
        if (i == 1) rb = 32'h8000_0000;
        run_op("rand", rm, ra, rb, ref_mul(rm, ra, rb));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
